elevator_scheduler: RTL and testbench



---
 rtl/elevator_pkg.sv | 25 ++
 rtl/elevator_req_bank.sv | 53 +++++
 rtl/elevator_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_elevator_scheduler.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/elevator_pkg.sv
// Shared types and defaults for the three-floor elevator request scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional watchdog state enabled by ELEVATOR_SCHED_WDOG_EN.
package elevator_pkg;

    localparam int N_FLOOR_DEF    = 3;
    // Floor index width; N_FLOOR must not exceed 2**FLOOR_W.
    localparam int FLOOR_W        = 2;
    localparam int SETTLE_CYC_DEF = 16;
    localparam int SETTLE_W       = 16;
    localparam int WDOG_W         = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MOVE_UP = 3'd1,
        MOVE_DN = 3'd2,
        STOP    = 3'd3,
        DOOR    = 3'd4
`ifdef ELEVATOR_SCHED_WDOG_EN
        ,
        FAULT   = 3'd5
`endif
    } state_e;

endpackage

// File: rtl/elevator_req_bank.sv
// Pending call register bank with clear-over-set priority, plus above/below/at reductions.
// Latency: set/clear visible one cycle after the strobe; reductions are combinational on the register.
// Backpressure: none; every strobe is absorbed, a masked set is simply lost.
module elevator_req_bank
    import elevator_pkg::*;
#(
    parameter int N_FLOOR = N_FLOOR_DEF
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [N_FLOOR-1:0] set_i,
    input  logic [N_FLOOR-1:0] clr_i,
    input  logic [FLOOR_W-1:0] cur_floor_i,
    output logic [N_FLOOR-1:0] pending_o,
    output logic               above_o,
    output logic               below_o,
    output logic               at_cur_o
);

    logic [N_FLOOR-1:0] pending_q;
    logic [N_FLOOR-1:0] pending_d;

    // A clear in the same cycle as a set wins.
    always_comb pending_d = (pending_q | set_i) & ~clr_i;

    // Pending register, emptied by reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pending_q <= '0;
        end else begin
            pending_q <= pending_d;
        end
    end

    // Reduce pending relative to the current floor for the SCAN decision.
    always_comb begin
        above_o  = 1'b0;
        below_o  = 1'b0;
        at_cur_o = 1'b0;
        for (int i = 0; i < N_FLOOR; i++) begin
            if (FLOOR_W'(i) > cur_floor_i) begin
                above_o = above_o | pending_q[i];
            end else if (FLOOR_W'(i) < cur_floor_i) begin
                below_o = below_o | pending_q[i];
            end else begin
                at_cur_o = at_cur_o | pending_q[i];
            end
        end
    end

    assign pending_o = pending_q;

endmodule

// File: rtl/elevator_scheduler.sv
// SCAN request scheduler for the elevator: latches calls, tracks floor, drives motor and door start.
// Latency: request->motor 2 cycles from IDLE; arrival->motor off 1 cycle, ->open 1+SETTLE_CYC cycles.
// Backpressure: none; door_done is only honoured in DOOR. Watchdog: ELEVATOR_SCHED_WDOG_EN.
module elevator_scheduler
    import elevator_pkg::*;
#(
    parameter int N_FLOOR    = N_FLOOR_DEF,
    parameter int SETTLE_CYC = SETTLE_CYC_DEF,
    parameter int WDOG_CYC   = 50_000_000
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [N_FLOOR-1:0] req_car,
    input  logic [N_FLOOR-1:0] req_hall,
    input  logic [N_FLOOR-1:0] at_floor,
    input  logic               door_done,
    output logic               up,
    output logic               down,
    output logic               open,
    output logic [N_FLOOR-1:0] pending,
    output logic [FLOOR_W-1:0] cur_floor,
    output logic               dir_up,
    output logic               fault
);

    localparam logic [FLOOR_W-1:0]  TOP_FLOOR   = FLOOR_W'(N_FLOOR - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYC - 1);

    state_e              state_q, state_d;
    logic                dir_up_q, dir_up_d;
    logic [FLOOR_W-1:0]  cur_floor_q, cur_floor_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic                open_q, open_d;

    logic                sensor_vld;
    logic [FLOOR_W-1:0]  sensor_idx;
    logic                arrive;
    logic                freeze;
    logic [N_FLOOR-1:0]  set_mask;
    logic [N_FLOOR-1:0]  clr_mask;
    logic [N_FLOOR-1:0]  pend;
    logic                pend_above, pend_below, pend_at_cur;

    // Decode the floor sensors; only an exact one-hot is trusted.
    always_comb begin
        sensor_vld = $onehot(at_floor);
        sensor_idx = '0;
        for (int i = 0; i < N_FLOOR; i++) begin
            if (at_floor[i]) begin
                sensor_idx = FLOOR_W'(i);
            end
        end
    end

    assign arrive      = sensor_vld && (sensor_idx != cur_floor_q);
    assign cur_floor_d = sensor_vld ? sensor_idx : cur_floor_q;

`ifdef ELEVATOR_SCHED_WDOG_EN
    assign freeze = (state_q == FAULT);
`else
    assign freeze = 1'b0;
`endif

    // While the door cycle runs the current floor is held clear, which also drops presses for it.
    assign set_mask = freeze ? '0 : (req_car | req_hall);
    assign clr_mask = (state_q == DOOR) ? (N_FLOOR'(1) << cur_floor_q) : '0;

    elevator_req_bank #(
        .N_FLOOR (N_FLOOR)
    ) u_req_bank (
        .clk         (clk),
        .rstn        (rstn),
        .set_i       (set_mask),
        .clr_i       (clr_mask),
        .cur_floor_i (cur_floor_q),
        .pending_o   (pend),
        .above_o     (pend_above),
        .below_o     (pend_below),
        .at_cur_o    (pend_at_cur)
    );

`ifdef ELEVATOR_SCHED_WDOG_EN
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYC - 1);
    logic [WDOG_W-1:0] wdog_q, wdog_d;

    // Move watchdog counter, idle at zero outside MOVE_*.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    logic [31:0] unused_wdog;
    assign unused_wdog = WDOG_CYC;
`endif

    // Next-state: SCAN ordering, settle count, door handshake and watchdog.
    always_comb begin
        state_d  = state_q;
        dir_up_d = dir_up_q;
        settle_d = '0;
`ifdef ELEVATOR_SCHED_WDOG_EN
        wdog_d   = '0;
`endif
        case (state_q)
            IDLE: begin
                if (pend_at_cur) begin
                    state_d = STOP;
                end else if (dir_up_q && pend_above) begin
                    state_d = MOVE_UP;
                end else if (!dir_up_q && pend_below) begin
                    state_d = MOVE_DN;
                end else if (pend_above) begin
                    dir_up_d = 1'b1;
                    state_d  = MOVE_UP;
                end else if (pend_below) begin
                    dir_up_d = 1'b0;
                    state_d  = MOVE_DN;
                end
            end
            MOVE_UP: begin
                if (arrive && (pend[sensor_idx] || sensor_idx == TOP_FLOOR)) begin
                    state_d = STOP;
                end
            end
            MOVE_DN: begin
                if (arrive && (pend[sensor_idx] || sensor_idx == '0)) begin
                    state_d = STOP;
                end
            end
            STOP: begin
                if (settle_q == SETTLE_LAST) begin
                    state_d = DOOR;
                end else begin
                    settle_d = settle_q + 16'd1;
                end
            end
            DOOR: begin
                if (door_done) begin
                    state_d = IDLE;
                end
            end
`ifdef ELEVATOR_SCHED_WDOG_EN
            FAULT: begin
                state_d = FAULT;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
`ifdef ELEVATOR_SCHED_WDOG_EN
        if (state_q == MOVE_UP || state_q == MOVE_DN) begin
            if (arrive) begin
                wdog_d = '0;
            end else if (wdog_q == WDOG_LAST) begin
                state_d = FAULT;
            end else begin
                wdog_d = wdog_q + 32'd1;
            end
        end
`endif
        open_d = (state_d == DOOR) && (state_q != DOOR);
    end

    // State, direction, floor and settle registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            dir_up_q    <= 1'b1;
            cur_floor_q <= '0;
            settle_q    <= '0;
            open_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_up_q    <= dir_up_d;
            cur_floor_q <= cur_floor_d;
            settle_q    <= settle_d;
            open_q      <= open_d;
        end
    end

    assign up        = (state_q == MOVE_UP);
    assign down      = (state_q == MOVE_DN);
    assign open      = open_q;
    assign pending   = pend;
    assign cur_floor = cur_floor_q;
    assign dir_up    = dir_up_q;
`ifdef ELEVATOR_SCHED_WDOG_EN
    assign fault     = (state_q == FAULT);
`else
    assign fault     = 1'b0;
`endif

endmodule

// File: tb/tb_elevator_scheduler.sv
// Scoreboard bench for elevator_scheduler: expected output events are queued by the stimulus.
// Latency: events are matched by absolute cycle number.
// Backpressure: n/a. Watchdog scenario runs only with ELEVATOR_SCHED_WDOG_EN.
module tb_elevator_scheduler;

    localparam int SETTLE = 16;
    localparam logic [2:0] V_NONE = 3'b000;
    localparam logic [2:0] V_UP   = 3'b100;
    localparam logic [2:0] V_DN   = 3'b010;
    localparam logic [2:0] V_OPEN = 3'b001;

    logic       clk       = 1'b0;
    logic       rstn      = 1'b0;
    logic [2:0] req_car   = '0;
    logic [2:0] req_hall  = '0;
    logic [2:0] at_floor  = 3'b001;
    logic       door_done = 1'b0;
    logic       up, down, open, dir_up, fault;
    logic [2:0] pending;
    logic [1:0] cur_floor;

    elevator_scheduler #(
        .N_FLOOR    (3),
        .SETTLE_CYC (SETTLE),
        .WDOG_CYC   (100)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_car   (req_car),
        .req_hall  (req_hall),
        .at_floor  (at_floor),
        .door_done (door_done),
        .up        (up),
        .down      (down),
        .open      (open),
        .pending   (pending),
        .cur_floor (cur_floor),
        .dir_up    (dir_up),
        .fault     (fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        int         cyc;
        logic [2:0] vec;
    } ev_t;
    ev_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int c, input logic [2:0] v);
        ev_t e;
        e.cyc = c;
        e.vec = v;
        exp_q.push_back(e);
    endtask

    // One-cycle request pulse; from IDLE the motor is expected two cycles later.
    task automatic request(input logic [2:0] car, input logic [2:0] hall, input logic [2:0] motor);
        int t;
        t        = cyc;
        req_car  = car;
        req_hall = hall;
        if (motor != V_NONE) push(t + 2, motor);
        tick(1);
        req_car  = '0;
        req_hall = '0;
    endtask

    // Leave the current floor and arrive at f; returns 19 cycles after arrival (inside DOOR).
    task automatic stop_at(input int f, input logic inj_done);
        int a;
        at_floor = '0;
        tick(2);
        a        = cyc;
        at_floor = 3'b001 << f;
        push(a + 1, V_NONE);
        push(a + 1 + SETTLE, V_OPEN);
        push(a + 2 + SETTLE, V_NONE);
        tick(4);
        door_done = inj_done;
        tick(1);
        door_done = 1'b0;
        tick(14);
    endtask

    // Close the door; the next move, if any, starts two cycles later.
    task automatic door_close(input logic [2:0] motor);
        int d;
        d         = cyc;
        door_done = 1'b1;
        if (motor != V_NONE) push(d + 2, motor);
        tick(1);
        door_done = 1'b0;
    endtask

    // Pass floor f without stopping.
    task automatic pass(input int f);
        at_floor = '0;
        tick(2);
        at_floor = 3'b001 << f;
        tick(1);
        check("pass_cur_floor", 32'(cur_floor), 32'(f));
    endtask

    // Monitor: every change of {up,down,open} is popped against the scoreboard.
    logic [2:0] prev_vec = V_NONE;
    always @(negedge clk) begin : mon
        logic [2:0] vec;
        ev_t        e;
        vec = {up, down, open};
        if (!rstn) begin
            prev_vec = V_NONE;
        end else begin
            n_cmp++;
            if (up && down) begin
                n_bad++;
                $display("FAIL up_down_both: up=%b down=%b, required not both 1 (cycle %0d)", up, down, cyc);
            end
            if (vec !== prev_vec) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event: got vec %b at cycle %0d, required no event", vec, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.cyc != cyc || e.vec !== vec) begin
                        n_bad++;
                        $display("FAIL event: got vec %b at cycle %0d, required vec %b at cycle %0d",
                                 vec, cyc, e.vec, e.cyc);
                    end
                end
                prev_vec = vec;
            end
        end
    end

    initial begin : timeout
        #400000;
        n_bad++;
        $display("FAIL timeout: bench did not finish within cycle budget");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1);
    end

    initial begin : stim
        int t;
        rstn = 1'b0;
        tick(3);
        check("rst_up",        32'(up),        0);
        check("rst_down",      32'(down),      0);
        check("rst_open",      32'(open),      0);
        check("rst_fault",     32'(fault),     0);
        check("rst_pending",   32'(pending),   0);
        check("rst_cur_floor", 32'(cur_floor), 0);
        check("rst_dir_up",    32'(dir_up),    1);
        rstn = 1'b1;
        tick(2);

        // Call at the parked floor: no motor, door opens after the settle period.
        t = cyc;
        push(t + 2 + SETTLE, V_OPEN);
        push(t + 3 + SETTLE, V_NONE);
        request(3'b000, 3'b001, V_NONE);
        check("park_pending_set", 32'(pending), 32'h1);
        tick(18);
        check("park_pending_clr", 32'(pending), 0);
        tick(1);
        door_close(V_NONE);

        // door_done outside DOOR is ignored.
        door_done = 1'b1;
        tick(1);
        door_done = 1'b0;
        tick(2);

        // Floor 0 to floor 2, passing floor 1.
        request(3'b100, 3'b000, V_UP);
        check("b_pending", 32'(pending), 32'h4);
        pass(1);
        stop_at(2, 1'b0);
        check("b_pending_clr", 32'(pending), 0);
        check("b_cur_floor",   32'(cur_floor), 2);
        door_close(V_NONE);

        // From floor 2 with nothing above: flip and go down to floor 1.
        request(3'b010, 3'b000, V_DN);
        tick(1);
        check("d_dir_flip_dn", 32'(dir_up), 0);
        stop_at(1, 1'b0);
        request(3'b010, 3'b000, V_NONE);
        check("d_door_press_drop", 32'(pending), 0);
        request(3'b100, 3'b001, V_NONE);
        check("d_pending_both", 32'(pending), 32'h5);
        door_close(V_DN);
        stop_at(0, 1'b0);
        check("d_pending_after0", 32'(pending), 32'h4);
        door_close(V_UP);
        tick(1);
        check("d_dir_flip_up", 32'(dir_up), 1);
        pass(1);
        stop_at(2, 1'b0);
        check("d_pending_done", 32'(pending), 0);
        door_close(V_NONE);

        // Down to 0 across a multi-hot glitch, door_done during STOP ignored.
        request(3'b001, 3'b000, V_DN);
        tick(1);
        at_floor = 3'b110;
        tick(1);
        check("c_multihot_hold", 32'(cur_floor), 2);
        pass(1);
        stop_at(0, 1'b1);
        door_close(V_NONE);

        // Up to 2 with a floor-1 call added during the move.
        request(3'b100, 3'b000, V_UP);
        tick(1);
        request(3'b010, 3'b000, V_NONE);
        check("c_pending_mid", 32'(pending), 32'h6);
        stop_at(1, 1'b0);
        check("c_pending_at1", 32'(pending), 32'h4);
        door_close(V_UP);
        stop_at(2, 1'b0);
        door_close(V_NONE);
        check("fault_idle", 32'(fault), 0);

        // Reset in the middle of a move.
        request(3'b001, 3'b000, V_DN);
        tick(2);
        rstn = 1'b0;
        #1;
        check("mid_rst_down",      32'(down),      0);
        check("mid_rst_pending",   32'(pending),   0);
        check("mid_rst_cur_floor", 32'(cur_floor), 0);
        check("mid_rst_dir_up",    32'(dir_up),    1);
        tick(2);
        rstn = 1'b1;
        tick(2);
        check("post_rst_floor", 32'(cur_floor), 2);

`ifdef ELEVATOR_SCHED_WDOG_EN
        // Move with no arrival trips the watchdog after 100 cycles.
        t = cyc;
        request(3'b001, 3'b000, V_DN);
        push(t + 102, V_NONE);
        tick(101);
        check("wdog_fault", 32'(fault), 1);
        check("wdog_down",  32'(down),  0);
        request(3'b010, 3'b000, V_NONE);
        check("wdog_frozen", 32'(pending), 32'h1);
        tick(2);
        rstn = 1'b0;
        #1;
        check("wdog_rst_fault",   32'(fault),   0);
        check("wdog_rst_pending", 32'(pending), 0);
        tick(1);
        rstn = 1'b1;
        tick(2);
`endif

        tick(5);
        check("queue_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
